// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial bit-pattern detector
//
// Purpose: recognises a runtime-loaded pattern of 1..MAX_LEN bits on a
// qualified serial line, in overlapping or non-overlapping mode, with a
// registered one-cycle match pulse and a saturating match counter.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_a_valid      serial sample qualifier
//   i_a            serial data bit
//   i_cfg_load     latch pattern/length/mode this cycle
//   i_cfg_pattern  pattern; bit [len-1] is the first bit received
//   i_cfg_len      pattern length (clamped to MAX_LEN)
//   i_cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   i_cnt_clr      clear the match counter
//   o_match        one-cycle registered match pulse
//   o_match_cnt    saturating match count
//   o_fill         accepted samples toward the current window
//   o_state        00 UNCFG, 01 FILL, 10 ARMED
module seq_detector_param #(
  parameter int  MAX_LEN = 8,
  parameter int  CNT_W   = 8,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_a_valid,
  input  logic               i_a,
  input  logic               i_cfg_load,
  input  logic [MAX_LEN-1:0] i_cfg_pattern,
  input  logic [LW-1:0]      i_cfg_len,
  input  logic               i_cfg_overlap,
  input  logic               i_cnt_clr,
  output logic               o_match,
  output logic [CNT_W-1:0]   o_match_cnt,
  output logic [LW-1:0]      o_fill,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {
    ST_UNCFG = 2'b00,
    ST_FILL  = 2'b01,
    ST_ARMED = 2'b10
  } state_t;

  localparam logic [LW-1:0]    LEN_MAX = LW'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             r_state;
  // Only the MAX_LEN-1 most recent bits are stored; the incoming bit
  // completes the full-width comparison window.
  logic [MAX_LEN-2:0] r_hist;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LW-1:0]      r_len;
  logic               r_overlap;
  logic [LW-1:0]      r_fill;
  logic               r_match;
  logic [CNT_W-1:0]   r_cnt;

  state_t             w_state_next;
  logic [MAX_LEN-2:0] w_hist_next;
  logic [LW-1:0]      w_fill_next;
  logic               w_hit;
  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_cmp;
  logic               w_accept;
  logic [LW-1:0]      w_len_clamped;
  logic [LW-1:0]      w_fill_inc;

  assign w_window      = {r_hist, i_a};
  assign w_len_clamped = (i_cfg_len > LEN_MAX) ? LEN_MAX : i_cfg_len;
  // A load in the same cycle wins over the sample, which is dropped.
  assign w_accept      = i_a_valid && !i_cfg_load && (r_state != ST_UNCFG);
  assign w_fill_inc    = r_fill + LW'(1);

  // Only the low len bits of window and pattern take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LW'(i) < r_len);
    end
  end

  assign w_cmp = (((w_window ^ r_pattern) & w_mask) == '0);

  always_comb begin
    w_state_next = r_state;
    w_hist_next  = r_hist;
    w_fill_next  = r_fill;
    w_hit        = 1'b0;
    if (i_cfg_load) begin
      w_hist_next  = '0;
      w_fill_next  = '0;
      w_state_next = (w_len_clamped != '0) ? ST_FILL : ST_UNCFG;
    end else if (w_accept) begin
      w_hist_next = w_window[MAX_LEN-2:0];
      case (r_state)
        ST_FILL: begin
          w_fill_next = w_fill_inc;
          if (w_fill_inc == r_len) begin
            if (w_cmp) begin
              w_hit = 1'b1;
              if (r_overlap) begin
                w_fill_next  = r_len;
                w_state_next = ST_ARMED;
              end else begin
                w_fill_next  = '0;
              end
            end else begin
              w_fill_next  = r_len;
              w_state_next = ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          w_fill_next = r_len;
          if (w_cmp) begin
            w_hit = 1'b1;
            if (!r_overlap) begin
              w_fill_next  = '0;
              w_state_next = ST_FILL;
            end
          end
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_UNCFG;
      r_hist    <= '0;
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_fill    <= '0;
      r_match   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_next;
      r_hist  <= w_hist_next;
      r_fill  <= w_fill_next;
      r_match <= w_hit;
      if (i_cfg_load) begin
        r_pattern <= i_cfg_pattern;
        r_len     <= w_len_clamped;
        r_overlap <= i_cfg_overlap;
      end
      // Clear beats a coincident hit; the pulse itself is still issued.
      if (i_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_hit && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_match     = r_match;
  assign o_match_cnt = r_cnt;
  assign o_fill      = r_fill;
  assign o_state     = r_state;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - bench for seq_detector_param
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0;
  logic       a = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       match8, match2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  logic [3:0] fill8, fill2;
  logic [1:0] state8, state2;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_a_valid(a_valid), .i_a(a),
    .i_cfg_load(cfg_load), .i_cfg_pattern(cfg_pattern), .i_cfg_len(cfg_len),
    .i_cfg_overlap(cfg_overlap), .i_cnt_clr(cnt_clr),
    .o_match(match8), .o_match_cnt(cnt8), .o_fill(fill8), .o_state(state8)
  );

  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_a_valid(a_valid), .i_a(a),
    .i_cfg_load(cfg_load), .i_cfg_pattern(cfg_pattern), .i_cfg_len(cfg_len),
    .i_cfg_overlap(cfg_overlap), .i_cnt_clr(cnt_clr),
    .o_match(match2), .o_match_cnt(cnt2), .o_fill(fill2), .o_state(state2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a match is the last len accepted bits equalling the pattern,
  // given at least len bits accepted since configuration (or, in
  // non-overlap mode, since the previous match).
  bit   m_cfg = 0;
  int   m_len = 0;
  logic [7:0] m_pat = '0;
  bit   m_ov = 0;
  int   m_since = 0;
  bit   m_q[$];
  bit   m_match = 0;
  int   m_cnt8 = 0;
  int   m_cnt2 = 0;

  always @(posedge clk) begin : model
    bit hit;
    hit = 0;
    if (rst) begin
      m_cfg = 0; m_len = 0; m_pat = '0; m_ov = 0; m_since = 0;
      m_q.delete(); m_match = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (cfg_load) begin
        m_len   = (int'(cfg_len) > 8) ? 8 : int'(cfg_len);
        m_cfg   = (m_len != 0);
        m_pat   = cfg_pattern;
        m_ov    = cfg_overlap;
        m_since = 0;
        m_q.delete();
      end else if (a_valid && m_cfg) begin
        m_q.push_front(a);
        if (m_q.size() > 8) void'(m_q.pop_back());
        if (m_since + 1 >= m_len) begin
          hit = 1;
          for (int k = 0; k < m_len; k++)
            if (m_q[k] != m_pat[k]) hit = 0;
        end
        if (hit && !m_ov) m_since = 0;
        else m_since = (m_since + 1 > m_len) ? m_len : m_since + 1;
      end
      m_match = hit;
      if (cnt_clr) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  end

  always @(negedge clk) begin : compare
    int exp_state, exp_fill;
    if (chk_en) begin
      exp_state = !m_cfg ? 0 : ((m_since >= m_len) ? 2 : 1);
      exp_fill  = m_cfg ? m_since : 0;
      check("model match8", match8, m_match);
      check("model match2", match2, m_match);
      check("model cnt8", cnt8, m_cnt8);
      check("model cnt2", cnt2, m_cnt2);
      check("model fill8", fill8, exp_fill);
      check("model fill2", fill2, exp_fill);
      check("model state8", state8, exp_state);
      check("model state2", state2, exp_state);
    end
  end

  task automatic tick(input logic v, input logic b, input logic clr);
    a_valid = v; a = b; cnt_clr = clr; cfg_load = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    a_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1; cfg_load = 1'b0; a_valid = 1'b0; cnt_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov,
                      input logic v, input logic b);
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    a_valid = v; a = b;
    @(posedge clk); #1;
    cfg_load = 1'b0; a_valid = 1'b0;
  endtask

  logic [6:0] stream1;
  logic [7:0] p8;

  initial begin
    stream1 = 7'b1011011;
    p8      = 8'b1011_0010;

    // reset state
    do_rst();
    chk_en = 1'b1;
    check("reset state", state8, 0);
    check("reset fill", fill8, 0);
    check("reset match", match8, 0);
    check("reset cnt", cnt8, 0);

    // 1: overlap, continuous stream
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, stream1[6-i], 1'b0);
      if (i == 3) begin
        check("t1 match s4", match8, 1);
        check("t1 state s4", state8, 2);
      end
      if (i == 4) check("t1 match s5", match8, 0);
      if (i == 6) begin
        check("t1 match s7", match8, 1);
        check("t1 cnt", cnt8, 2);
      end
    end

    // 2: non-overlap, same stream
    do_rst();
    load(8'b0000_1011, 4'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, stream1[6-i], 1'b0);
      if (i == 3) begin
        check("t2 match s4", match8, 1);
        check("t2 fill s4", fill8, 0);
      end
      if (i >= 4) check("t2 fill", fill8, i - 3);
      if (i == 6) begin
        check("t2 match s7", match8, 0);
        check("t2 cnt", cnt8, 1);
        check("t2 state", state8, 1);
      end
    end

    // 3: qualifier gaps
    do_rst();
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, stream1[6-i], 1'b0);
      for (int g = 0; g < 3; g++) begin
        tick(1'b0, 1'b1, 1'b0);
        if (i == 3 && g == 0) check("t3 gap match", match8, 0);
        if (i == 1) check("t3 gap fill", fill8, 2);
      end
    end
    check("t3 cnt", cnt8, 2);
    check("t3 state", state8, 2);

    // 4: saturation and clear
    do_rst();
    load(8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      check("t4 cnt2", cnt2, (i + 1 > 3) ? 3 : i + 1);
      check("t4 cnt8", cnt8, i + 1);
    end
    tick(1'b1, 1'b1, 1'b1);
    check("t4 clr match", match2, 1);
    check("t4 clr cnt2", cnt2, 0);
    check("t4 clr cnt8", cnt8, 0);

    // len=1 non-overlap
    load(8'b0000_0001, 4'd1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("l1 match a", match8, 1);
    check("l1 fill a", fill8, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("l1 match b", match8, 0);
    check("l1 fill b", fill8, 1);
    check("l1 state b", state8, 2);
    tick(1'b1, 1'b1, 1'b0);
    check("l1 match c", match8, 1);
    check("l1 state c", state8, 1);

    // 5: config edge cases
    load(8'hFF, 4'd0, 1'b1, 1'b0, 1'b0);
    check("t5 len0 state", state8, 0);
    tick(1'b1, 1'b1, 1'b0);
    check("t5 len0 match", match8, 0);
    check("t5 len0 fill", fill8, 0);
    load(p8, 4'd15, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, p8[7-i], 1'b0);
      if (i == 6) check("t5 clamp s7", match8, 0);
      if (i == 7) begin
        check("t5 clamp s8", match8, 1);
        check("t5 clamp fill", fill8, 8);
      end
    end
    load(8'b0000_1011, 4'd4, 1'b1, 1'b1, 1'b1);
    check("t5 load+valid fill", fill8, 0);
    tick(1'b1, 1'b1, 1'b0);
    check("t5 next fill", fill8, 1);

    // 6: reset mid-window
    do_rst();
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("t6 fill pre", fill8, 3);
    do_rst();
    check("t6 state", state8, 0);
    check("t6 fill", fill8, 0);
    check("t6 cnt", cnt8, 0);
    tick(1'b1, 1'b1, 1'b0);
    check("t6 match", match8, 0);
    check("t6 state after", state8, 0);

    tick(1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
